// File: rtl/audio_pkg.sv
// Shared audio definitions: note half-periods, note/state enums and the note classifier.
package audio_pkg;

    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned NOTE_HALF_A3 = 114091;
    localparam int unsigned NOTE_HALF_G3 = 128061;
    localparam int unsigned NOTE_HALF_F3 = 143757;

    typedef enum logic [1:0] {
        NOTE_NONE = 2'd0,
        NOTE_A3   = 2'd1,
        NOTE_G3   = 2'd2,
        NOTE_F3   = 2'd3
    } note_id_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMeasHigh = 2'd1,
        StMeasLow  = 2'd2
    } tone_dec_state_t;

    function automatic logic within_tol(input int unsigned cnt, input int unsigned target,
                                        input int unsigned tol);
        int unsigned diff;
        diff = (cnt > target) ? (cnt - target) : (target - cnt);
        return diff <= tol;
    endfunction

    // First match wins, in order A3, G3, F3.
    function automatic note_id_t classify_note(input int unsigned hcnt, input int unsigned lcnt,
                                               input int unsigned half_a3,
                                               input int unsigned half_g3,
                                               input int unsigned half_f3,
                                               input int unsigned tol);
        if (within_tol(hcnt, half_a3, tol) && within_tol(lcnt, half_a3, tol)) return NOTE_A3;
        if (within_tol(hcnt, half_g3, tol) && within_tol(lcnt, half_g3, tol)) return NOTE_G3;
        if (within_tol(hcnt, half_f3, tol) && within_tol(lcnt, half_f3, tol)) return NOTE_F3;
        return NOTE_NONE;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a one-flop edge register producing rise/fall pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/tone_decoder.sv
// Measures high time and period of a 1-bit square wave and classifies it as a game note.
module tone_decoder
    import audio_pkg::*;
#(
    parameter int unsigned HALF_W         = 18,
    parameter int unsigned TOL            = 64,
    parameter int unsigned SILENCE_CYCLES = 200000,
    parameter int unsigned HALF_A3        = NOTE_HALF_A3,
    parameter int unsigned HALF_G3        = NOTE_HALF_G3,
    parameter int unsigned HALF_F3        = NOTE_HALF_F3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              audio_in,
    output logic [HALF_W-1:0] high_time,
    output logic [HALF_W:0]   period,
    output logic [1:0]        note_id,
    output logic              note_valid,
    output logic              silent
);

    localparam logic [HALF_W-1:0] CntOne     = HALF_W'(1);
    localparam logic [HALF_W-1:0] CntMax     = '1;
    localparam logic [HALF_W-1:0] SilenceCnt = HALF_W'(SILENCE_CYCLES);

    logic rise, fall;

    tone_dec_state_t   state_q, state_d;
    logic [HALF_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [HALF_W-1:0] high_time_q, high_time_d;
    logic [HALF_W:0]   period_q, period_d;
    note_id_t          note_q, note_d;
    logic              valid_q, valid_d;
    logic              silent_q, silent_d;

    sync_edge_detect u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (audio_in),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        lcnt_d      = lcnt_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        note_d      = note_q;
        valid_d     = 1'b0;
        silent_d    = silent_q;

        if (!enable) begin
            state_d  = StIdle;
            silent_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StMeasHigh;
                        hcnt_d  = CntOne;
                        lcnt_d  = '0;
                    end
                end
                StMeasHigh: begin
                    // An edge takes priority over the silence timeout.
                    if (fall) begin
                        state_d = StMeasLow;
                        lcnt_d  = CntOne;
                    end else if (hcnt_q >= SilenceCnt) begin
                        state_d  = StIdle;
                        silent_d = 1'b1;
                    end else if (hcnt_q != CntMax) begin
                        hcnt_d = hcnt_q + CntOne;
                    end
                end
                StMeasLow: begin
                    if (rise) begin
                        high_time_d = hcnt_q;
                        period_d    = {1'b0, hcnt_q} + {1'b0, lcnt_q};
                        note_d      = classify_note(32'(hcnt_q), 32'(lcnt_q), HALF_A3,
                                                    HALF_G3, HALF_F3, TOL);
                        valid_d     = 1'b1;
                        silent_d    = 1'b0;
                        state_d     = StMeasHigh;
                        hcnt_d      = CntOne;
                        lcnt_d      = '0;
                    end else if (lcnt_q >= SilenceCnt) begin
                        state_d  = StIdle;
                        silent_d = 1'b1;
                    end else if (lcnt_q != CntMax) begin
                        lcnt_d = lcnt_q + CntOne;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            note_q      <= NOTE_NONE;
            valid_q     <= 1'b0;
            silent_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            note_q      <= note_d;
            valid_q     <= valid_d;
            silent_q    <= silent_d;
        end
    end

    assign high_time  = high_time_q;
    assign period     = period_q;
    assign note_id    = note_q;
    assign note_valid = valid_q;
    assign silent     = silent_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with note half-periods scaled down to keep runs short.
module tb_tone_decoder;

    localparam int unsigned HW  = 10;
    localparam int unsigned TL  = 4;
    localparam int unsigned SIL = 300;

    logic          clk = 1'b0;
    logic          rst_n, enable, audio_in;
    logic [HW-1:0] high_time;
    logic [HW:0]   period;
    logic [1:0]    note_id;
    logic          note_valid, silent;

    tone_decoder #(
        .HALF_W        (HW),
        .TOL           (TL),
        .SILENCE_CYCLES(SIL),
        .HALF_A3       (114),
        .HALF_G3       (128),
        .HALF_F3       (144)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .audio_in  (audio_in),
        .high_time (high_time),
        .period    (period),
        .note_id   (note_id),
        .note_valid(note_valid),
        .silent    (silent)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   nv_count = 0;
    int   last_h = 0, last_p = 0, last_n = 0;
    logic prev_nv = 1'b0;
    logic dbl_pulse = 1'b0;

    always @(negedge clk) begin
        if (note_valid) begin
            nv_count <= nv_count + 1;
            last_h   <= int'(high_time);
            last_p   <= int'(period);
            last_n   <= int'(note_id);
        end
        if (note_valid && prev_nv) dbl_pulse <= 1'b1;
        prev_nv <= note_valid;
    end

    typedef struct {
        int h;
        int l;
        int n;
        int note;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_tone(input int h, input int l, input int n);
        repeat (n) begin
            audio_in = 1'b1;
            tick(h);
            audio_in = 1'b0;
            tick(l);
        end
    endtask

    initial begin
        int exp_cnt;
        int base;

        vecs[0] = '{114, 115, 3, 1};
        vecs[1] = '{128, 128, 2, 2};
        vecs[2] = '{144, 144, 2, 3};
        vecs[3] = '{100, 100, 2, 0};
        vecs[4] = '{118, 110, 2, 1};  // both halves at the tolerance edge of A3
        vecs[5] = '{119, 114, 2, 0};  // high half one cycle outside A3 tolerance
        vecs[6] = '{124, 124, 2, 2};

        rst_n    = 1'b0;
        enable   = 1'b1;
        audio_in = 1'b0;
        tick(3);
        check("rst_high_time", int'(high_time), 0);
        check("rst_period", int'(period), 0);
        check("rst_note_id", int'(note_id), 0);
        check("rst_note_valid", int'(note_valid), 0);
        check("rst_silent", int'(silent), 1);
        rst_n = 1'b1;
        tick(2);

        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            drive_tone(vecs[i].h, vecs[i].l, vecs[i].n);
            exp_cnt += (i == 0) ? vecs[i].n - 1 : vecs[i].n;
            check($sformatf("vec%0d_note", i), last_n, vecs[i].note);
            check($sformatf("vec%0d_high", i), last_h, vecs[i].h);
            check($sformatf("vec%0d_period", i), last_p, vecs[i].h + vecs[i].l);
            check($sformatf("vec%0d_pulses", i), nv_count, exp_cnt);
            check($sformatf("vec%0d_silent", i), int'(silent), 0);
        end

        // Silence: low held until the timeout fires.
        base     = nv_count;
        audio_in = 1'b1;
        tick(114);
        audio_in = 1'b0;
        tick(SIL + 2);
        check("silence_before", int'(silent), 0);
        tick(1);
        check("silence_at", int'(silent), 1);
        check("silence_pulses", nv_count, base + 1);

        // After silence the first rise only restarts measurement.
        base     = nv_count;
        audio_in = 1'b1;
        tick(20);
        audio_in = 1'b0;
        tick(20);
        check("single_rise_no_pulse", nv_count, base);
        check("single_rise_silent", int'(silent), 1);
        audio_in = 1'b1;
        tick(10);
        check("second_rise_pulse", nv_count, base + 1);
        check("second_rise_high", last_h, 20);
        check("second_rise_period", last_p, 40);
        check("second_rise_note", last_n, 0);
        check("second_rise_silent", int'(silent), 0);

        // Reset mid MEAS_LOW.
        audio_in = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #1;
        check("midrst_high_time", int'(high_time), 0);
        check("midrst_period", int'(period), 0);
        check("midrst_note_id", int'(note_id), 0);
        check("midrst_note_valid", int'(note_valid), 0);
        check("midrst_silent", int'(silent), 1);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Enable drops in the same cycle the FSM sees rise in MEAS_LOW.
        audio_in = 1'b1;
        tick(10);
        audio_in = 1'b0;
        tick(10);
        base     = nv_count;
        audio_in = 1'b1;
        tick(2);
        enable = 1'b0;
        tick(1);
        check("en_drop_valid", int'(note_valid), 0);
        tick(20);
        check("en_drop_pulses", nv_count, base);
        check("en_drop_silent", int'(silent), 1);
        check("en_drop_hold_period", int'(period), 0);

        // Re-enable with input high: no false edge.
        enable = 1'b1;
        tick(10);
        check("reenable_no_pulse", nv_count, base);
        audio_in = 1'b0;
        tick(10);
        audio_in = 1'b1;
        tick(10);
        audio_in = 1'b0;
        tick(12);
        check("reenable_silent", int'(silent), 1);
        audio_in = 1'b1;
        tick(2);
        check("latency_pre", int'(note_valid), 0);
        tick(1);
        check("latency_valid", int'(note_valid), 1);
        check("latency_high", int'(high_time), 10);
        check("latency_period", int'(period), 22);
        check("latency_note", int'(note_id), 0);
        check("latency_silent", int'(silent), 0);
        tick(1);
        check("latency_post", int'(note_valid), 0);
        tick(5);

        check("no_back_to_back_valid", int'(dbl_pulse), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
